// File: rtl/spike_synapse.sv
// Edge-triggered synapse: converts upstream spike edges into a leaky stimulus current,
// enforces a refractory period after each accepted spike, and reports windowed spike rate.
module spike_synapse #(
    parameter int DECAY_SHIFT = 3,
    parameter int REFRACT     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_spike,
    input  logic [7:0] weight,
    input  logic       en,
    output logic [7:0] syn_current,
    output logic       syn_event,
    output logic       busy,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic [7:0] dropped,
    output logic       dbg_state
);

    // Handshake: syn_event and rate_valid are one-cycle valid strobes with no ready;
    // syn_current / rate are meaningful in the strobe cycle and the consumer must take them then.

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_REFRACT = 1'b1
    } state_t;

    localparam logic [3:0] REFRACT_LD = 4'(REFRACT);

    state_t     state;
    state_t     state_next;
    logic [3:0] timer;
    logic [3:0] timer_next;
    logic       prev;
    logic       spike_edge;
    logic       accept;
    logic       reject;

    logic [7:0] shifted;
    logic [7:0] leak;
    logic [8:0] sum;
    logic [7:0] cur_next;

    logic [7:0] wcnt;
    logic [7:0] acc;
    logic [7:0] acc_inc;

    // prev resets high so a level already present at reset release is not an edge
    assign spike_edge = pre_spike & ~prev;
    assign accept     = spike_edge & en & (state == ST_IDLE);
    assign reject     = spike_edge & ~accept;
    assign busy       = (state == ST_REFRACT);
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_REFRACT;
                    timer_next = REFRACT_LD;
                end
            end
            ST_REFRACT: begin
                timer_next = timer - 4'd1;
                if (timer == 4'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = 4'd0;
            end
        endcase
    end

    // Leak always makes progress: small currents whose shifted value is zero still drop by one
    always_comb begin
        shifted = syn_current >> DECAY_SHIFT;
        leak    = 8'd0;
        if (syn_current != 8'd0) begin
            if (shifted == 8'd0) begin
                leak = syn_current - 8'd1;
            end else begin
                leak = syn_current - shifted;
            end
        end
        sum      = {1'b0, leak} + {1'b0, weight};
        cur_next = leak;
        if (accept) begin
            cur_next = sum[8] ? 8'hFF : sum[7:0];
        end
    end

    always_comb begin
        acc_inc = acc;
        if (accept && acc != 8'hFF) begin
            acc_inc = acc + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            timer <= 4'd0;
            prev  <= 1'b1;
        end else begin
            state <= state_next;
            timer <= timer_next;
            prev  <= pre_spike;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syn_current <= 8'd0;
            syn_event   <= 1'b0;
            dropped     <= 8'd0;
        end else begin
            syn_current <= cur_next;
            syn_event   <= accept;
            if (reject && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    // An accept in the closing cycle of a window belongs to that window only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt       <= 8'd0;
            acc        <= 8'd0;
            rate       <= 8'd0;
            rate_valid <= 1'b0;
        end else begin
            wcnt <= wcnt + 8'd1;
            if (wcnt == 8'hFF) begin
                rate       <= acc_inc;
                acc        <= 8'd0;
                rate_valid <= 1'b1;
            end else begin
                acc        <= acc_inc;
                rate_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse: stimulus pushes expected currents/rates into queues,
// a forked monitor pops and compares whenever syn_event or rate_valid is presented.
module tb_spike_synapse;

    logic       clk;
    logic       rst_n;
    logic       pre_spike;
    logic [7:0] weight;
    logic       en;
    logic [7:0] syn_current;
    logic       syn_event;
    logic       busy;
    logic [7:0] rate;
    logic       rate_valid;
    logic [7:0] dropped;
    logic       dbg_state;

    logic [7:0] exp_q[$];
    logic [7:0] rate_q[$];

    int n_checks;
    int n_fail;
    int rate_seen;
    int last_rv_cyc;
    int cyc;

    spike_synapse #(.DECAY_SHIFT(3), .REFRACT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .weight     (weight),
        .en         (en),
        .syn_current(syn_current),
        .syn_event  (syn_event),
        .busy       (busy),
        .rate       (rate),
        .rate_valid (rate_valid),
        .dropped    (dropped),
        .dbg_state  (dbg_state)
    );

    // clock / reset-relative cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle spike level; weight is randomised outside the accept cycle
    task automatic spike(input logic [7:0] w, input logic en_v);
        pre_spike = 1'b1;
        weight    = w;
        en        = en_v;
        step();
        pre_spike = 1'b0;
        en        = 1'b1;
        weight    = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_rate(input int n);
        for (int k = 0; k < 400 && rate_seen < n; k++) step();
        check("rate_valid_seen", rate_seen, n);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (syn_event) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got current %0d expected no event", syn_current);
                end else begin
                    e = exp_q.pop_front();
                    check("event_current", syn_current, e);
                end
            end
            if (rate_valid) begin
                rate_seen++;
                last_rv_cyc = cyc;
                if (rate_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rate: got %0d expected no rate_valid", rate);
                end else begin
                    e = rate_q.pop_front();
                    check("rate_value", rate, e);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] tail[6];
        logic [7:0] sat_tr[4];
        n_checks    = 0;
        n_fail      = 0;
        rate_seen   = 0;
        last_rv_cyc = 0;
        rst_n       = 1'b0;
        pre_spike   = 1'b1;
        weight      = 8'd0;
        en          = 1'b1;
        fork
            monitor();
        join_none

        // reset state, with pre_spike already high
        repeat (3) step();
        check("rst_current", syn_current, 0);
        check("rst_event", syn_event, 0);
        check("rst_busy", busy, 0);
        check("rst_rate", rate, 0);
        check("rst_rate_valid", rate_valid, 0);
        check("rst_dropped", dropped, 0);
        rst_n = 1'b1;
        step();
        check("no_edge_at_release_event", syn_event, 0);
        check("no_edge_at_release_busy", busy, 0);
        pre_spike = 1'b0;
        step();

        // window 0: four accepts
        rate_q.push_back(8'd4);

        // small current leaks by one per cycle down to zero
        exp_q.push_back(8'd5);
        spike(8'd5, 1'b1);
        tail = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        for (int i = 0; i < 6; i++) begin
            step();
            check("leak_small", syn_current, tail[i]);
        end

        // edges while disabled are dropped and leave the current alone
        spike(8'd200, 1'b0);
        step();
        spike(8'd200, 1'b0);
        step();
        check("en0_dropped", dropped, 2);
        check("en0_current", syn_current, 0);
        check("en0_busy", busy, 0);

        // weight 100 from rest: 100, 88, 77, 68
        exp_q.push_back(8'd100);
        spike(8'd100, 1'b1);
        step();
        check("decay_t2", syn_current, 88);
        step();
        check("decay_t3", syn_current, 77);
        step();
        check("decay_t4", syn_current, 68);
        repeat (60) step();
        check("decayed_to_zero", syn_current, 0);

        // refractory: edges at t, t+2, t+5 with weight 0
        exp_q.push_back(8'd0);
        spike(8'd0, 1'b1);
        check("busy_t1", busy, 1);
        step();
        check("busy_t2", busy, 1);
        spike(8'd0, 1'b1);
        check("busy_t3", busy, 1);
        step();
        check("busy_t4", busy, 1);
        step();
        check("idle_t5", busy, 0);
        exp_q.push_back(8'd0);
        spike(8'd0, 1'b1);
        check("busy_t6", busy, 1);
        check("refract_dropped", dropped, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_t7_t9", busy, 1);
        end
        step();
        check("idle_t10", busy, 0);

        wait_rate(1);
        check("window0_end_cycle", last_rv_cyc, 256);

        // window 1: saturation pair plus an accept in its closing cycle
        rate_q.push_back(8'd3);
        exp_q.push_back(8'd255);
        spike(8'd255, 1'b1);
        sat_tr = '{8'd224, 8'd196, 8'd172, 8'd151};
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_decay", syn_current, sat_tr[i]);
        end
        exp_q.push_back(8'd255);
        spike(8'd255, 1'b1);
        for (int k = 0; k < 600 && cyc != 511; k++) step();
        check("reach_cycle_511", cyc, 511);
        exp_q.push_back(8'd0);
        spike(8'd0, 1'b1);
        wait_rate(2);
        check("window1_end_cycle", last_rv_cyc, 512);

        // window 2: the boundary accept must not be counted again
        rate_q.push_back(8'd1);
        repeat (10) step();
        exp_q.push_back(8'd0);
        spike(8'd0, 1'b1);
        wait_rate(3);
        check("rate_held", rate, 1);

        // reset in the middle of refractory
        exp_q.push_back(8'd50);
        spike(8'd50, 1'b1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        step();
        check("midrst_current", syn_current, 0);
        check("midrst_event", syn_event, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rate", rate, 0);
        check("midrst_rate_valid", rate_valid, 0);
        check("midrst_dropped", dropped, 0);
        rst_n = 1'b1;
        rate_q.push_back(8'd0);
        wait_rate(4);
        check("window_after_reset_cycle", last_rv_cyc, 256);

        step();
        check("exp_q_drained", exp_q.size(), 0);
        check("rate_q_drained", rate_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_synapse.md
SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 Parameter DECAY_SHIFT, default 3, SHALL set the per-cycle leak of syn_current (cur >> DECAY_SHIFT); legal 1..7.
REQ-002 Parameter REFRACT, default 4, SHALL set the refractory length in cycles after each accepted spike; legal 1..15.
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 pre_spike  input  1  SHALL be the level spike output of the upstream neuron.
REQ-006 weight  input  8  SHALL be the unsigned synaptic weight, sampled in the cycle a spike is accepted.
REQ-007 en  input  1  SHALL enable acceptance when high; leak and timers run regardless.
REQ-008 syn_current  output  8  SHALL be the registered unsigned stimulus current for the downstream neuron.
REQ-009 event  output  1  SHALL be a registered one-cycle pulse per accepted spike.
REQ-010 busy  output  1  SHALL be high while in the REFRACT state.
REQ-011 rate  output  8  SHALL be the accepted-spike count of the last completed 256-cycle window.
REQ-012 rate_valid  output  1  SHALL be a one-cycle pulse when rate updates.
REQ-013 dropped  output  8  SHALL be a saturating count of rejected spike edges since reset.

Function
REQ-014 Edge: edge = pre_spike & ~prev; prev registered each cycle and reset to 1, so a high level at reset release is not an edge.
REQ-015 FSM states IDLE and REFRACT; busy = (state == REFRACT).
REQ-016 Accept = edge & en & IDLE; on accept, next state REFRACT and 4-bit timer loaded with REFRACT.
REQ-017 In REFRACT, timer decrements each cycle; in the cycle timer == 1 the next state is IDLE; edge at timer == 0 is in IDLE.
REQ-018 Spike edge at cycle t accepted -> busy high cycles t+1..t+REFRACT; edges in those cycles rejected; edge at t+REFRACT+1 acceptable.
REQ-019 Rejected edge (en low or REFRACT) SHALL increment dropped, saturating at 255.
REQ-020 Leak: L = cur - (cur >> DECAY_SHIFT); if cur != 0 and (cur >> DECAY_SHIFT) == 0, L = cur - 1; L = 0 when cur = 0.
REQ-021 syn_current next = accept ? min(L + weight, 255) : L; sum computed 9-bit, saturated to 8.
REQ-022 event next = accept; latency edge-to-event and edge-to-current = 1 cycle.
REQ-023 Window counter wcnt 8-bit free-running from 0, wraps 255 -> 0.
REQ-024 Accumulator acc counts accepts, saturating at 255.
REQ-025 In cycle wcnt == 255: rate <= sat(acc + accept), acc <= 0, rate_valid <= 1 next cycle; an accept in that cycle counts in the closing window only.
REQ-026 weight = 0 accept SHALL still pulse event, start refractory, and count in rate.

Reset
REQ-027 While rst_n low at posedge: syn_current=0, event=0, busy=0 (IDLE), timer=0, rate=0, rate_valid=0, dropped=0, acc=0, wcnt=0, prev=1.
REQ-028 Reset mid-refractory or mid-window SHALL abort all state; first window after reset ends 256 cycles after reset release.

Verification
REQ-029 Defaults, cur=0, weight=100, edge at t -> syn_current=100, event=1 at t+1; 88, 77, 68 at t+2..t+4.
REQ-030 cur=200, weight=100, edge -> syn_current=255 next cycle (175+100 saturated).
REQ-031 cur=5, no edges -> 4,3,2,1,0 then holds 0.
REQ-032 REFRACT=4, edges at t, t+2, t+5 -> accepts at t and t+5, dropped=1, busy high t+1..t+4 and t+6..t+9.
REQ-033 3 accepted spikes in window 0 -> rate=3, rate_valid pulse at cycle 256 after reset; acc restarts at 0.
REQ-034 en=0 with 2 edges -> no event, syn_current unaffected by weight, dropped=2; rst_n low mid-REFRACT -> all outputs 0 next cycle.
